// File: rtl/alu_rs_if.sv
// alu_rs_if: decoder issue, load broadcast and ROB writeback bundle for alu_rs.
// Also holds the shared ROB tag width and op_type encoding.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif
`ifndef ALU_RS_OPS
`define ALU_RS_OPS
`define OP_ADD   6'd0
`define OP_SUB   6'd1
`define OP_AND   6'd2
`define OP_OR    6'd3
`define OP_XOR   6'd4
`define OP_SLL   6'd5
`define OP_SRL   6'd6
`define OP_SRA   6'd7
`define OP_SLT   6'd8
`define OP_SLTU  6'd9
`define OP_ADDI  6'd10
`define OP_ANDI  6'd11
`define OP_ORI   6'd12
`define OP_XORI  6'd13
`define OP_SLLI  6'd14
`define OP_SRLI  6'd15
`define OP_SRAI  6'd16
`define OP_SLTI  6'd17
`define OP_SLTIU 6'd18
`define OP_LUI   6'd19
`define OP_AUIPC 6'd20
`define OP_JAL   6'd21
`define OP_JALR  6'd22
`define OP_BEQ   6'd23
`define OP_BNE   6'd24
`define OP_BLT   6'd25
`define OP_BGE   6'd26
`define OP_BLTU  6'd27
`define OP_BGEU  6'd28
`endif
interface alu_rs_if;
  logic                      rdy_in;
  logic                      clear_all;
  logic [`ROB_WIDTH_BIT-1:0] rob_head;
  logic                      issue_valid;
  logic [5:0]                issue_op;
  logic [`ROB_WIDTH_BIT-1:0] issue_dest;
  logic [31:0]               issue_pc;
  logic [31:0]               issue_vj;
  logic [31:0]               issue_vk;
  logic                      issue_qj_busy;
  logic                      issue_qk_busy;
  logic [`ROB_WIDTH_BIT-1:0] issue_qj;
  logic [`ROB_WIDTH_BIT-1:0] issue_qk;
  logic                      rs_full;
  logic                      lb_to_rob;
  logic [31:0]               lb_value;
  logic [`ROB_WIDTH_BIT-1:0] lb_dest;
  logic                      rs_to_rob;
  logic [31:0]               rs_value;
  logic [`ROB_WIDTH_BIT-1:0] rs_dest;
  modport master (
    output rdy_in, clear_all, rob_head, issue_valid, issue_op, issue_dest, issue_pc,
           issue_vj, issue_vk, issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           lb_to_rob, lb_value, lb_dest,
    input  rs_full, rs_to_rob, rs_value, rs_dest
  );
  modport slave (
    input  rdy_in, clear_all, rob_head, issue_valid, issue_op, issue_dest, issue_pc,
           issue_vj, issue_vk, issue_qj_busy, issue_qk_busy, issue_qj, issue_qk,
           lb_to_rob, lb_value, lb_dest,
    output rs_full, rs_to_rob, rs_value, rs_dest
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: reservation station + integer ALU feeding the ROB writeback channel.
// Define RS_OLDEST_FIRST_EN to dispatch the ready entry oldest relative to rob_head instead of the lowest index.
module alu_rs #(
  parameter int RS_SIZE    = 8,
  parameter int RS_IDX_BIT = 3
) (
  input logic     clk_in,
  input logic     rst_in,
  alu_rs_if.slave bus
);
  localparam int W = `ROB_WIDTH_BIT;
  logic [RS_SIZE-1:0] busy_q, qjb_q, qkb_q, ready;
  logic [5:0]         op_q   [RS_SIZE];
  logic [W-1:0]       dest_q [RS_SIZE];
  logic [W-1:0]       qj_q   [RS_SIZE];
  logic [W-1:0]       qk_q   [RS_SIZE];
  logic [31:0]        pc_q   [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vk_q   [RS_SIZE];
  logic               rs_to_rob_q;
  logic [31:0]        rs_value_q;
  logic [W-1:0]       rs_dest_q;
  logic [RS_IDX_BIT-1:0] sel, free_idx;
  logic               sel_vld, full;
  logic [31:0]        a, b, pc, res;
  logic               lb_v;
  logic [W-1:0]       lb_d;
  logic [31:0]        lb_val;
  assign lb_v   = bus.lb_to_rob;
  assign lb_d   = bus.lb_dest;
  assign lb_val = bus.lb_value;
  assign full   = &busy_q;
  assign bus.rs_full   = full;
  assign bus.rs_to_rob = rs_to_rob_q;
  assign bus.rs_value  = rs_value_q;
  assign bus.rs_dest   = rs_dest_q;
  for (genvar g = 0; g < RS_SIZE; g++) begin : g_rdy
    assign ready[g] = busy_q[g] & ~qjb_q[g] & ~qkb_q[g];
  end
  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) if (!busy_q[i]) free_idx = RS_IDX_BIT'(i);
  end
`ifdef RS_OLDEST_FIRST_EN
  logic [W-1:0] best_age;
  always_comb begin
    sel = '0;
    sel_vld = 1'b0;
    best_age = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (ready[i] && (!sel_vld || W'(dest_q[i] - bus.rob_head) < best_age)) begin
        sel = RS_IDX_BIT'(i);
        sel_vld = 1'b1;
        best_age = W'(dest_q[i] - bus.rob_head);
      end
  end
`else
  logic unused_head;
  assign unused_head = ^bus.rob_head;
  assign sel_vld = |ready;
  always_comb begin
    sel = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) if (ready[i]) sel = RS_IDX_BIT'(i);
  end
`endif
  assign a  = vj_q[sel];
  assign b  = vk_q[sel];
  assign pc = pc_q[sel];
  always_comb begin
    case (op_q[sel])
      `OP_ADD, `OP_ADDI:   res = a + b;
      `OP_SUB:             res = a - b;
      `OP_AND, `OP_ANDI:   res = a & b;
      `OP_OR, `OP_ORI:     res = a | b;
      `OP_XOR, `OP_XORI:   res = a ^ b;
      `OP_SLL, `OP_SLLI:   res = a << b[4:0];
      `OP_SRL, `OP_SRLI:   res = a >> b[4:0];
      `OP_SRA, `OP_SRAI:   res = $unsigned($signed(a) >>> b[4:0]);
      `OP_SLT, `OP_SLTI:   res = {31'd0, $signed(a) < $signed(b)};
      `OP_SLTU, `OP_SLTIU: res = {31'd0, a < b};
      `OP_LUI:             res = b;
      `OP_AUIPC:           res = pc + b;
      `OP_JAL, `OP_JALR:   res = pc + 32'd4;
      `OP_BEQ:             res = {31'd0, a == b};
      `OP_BNE:             res = {31'd0, a != b};
      `OP_BLT:             res = {31'd0, $signed(a) < $signed(b)};
      `OP_BGE:             res = {31'd0, $signed(a) >= $signed(b)};
      `OP_BLTU:            res = {31'd0, a < b};
      `OP_BGEU:            res = {31'd0, a >= b};
      default:             res = '0;
    endcase
  end
  // returns {still_pending, value}; both broadcasts are visible to issue and to resident entries
  function automatic logic [32:0] snoop(input logic p, input logic [W-1:0] t, input logic [31:0] v);
    return (p && lb_v && lb_d == t) ? {1'b0, lb_val} :
           (p && rs_to_rob_q && rs_dest_q == t) ? {1'b0, rs_value_q} : {p, v};
  endfunction
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      rs_to_rob_q <= 1'b0;
      rs_value_q  <= '0;
      rs_dest_q   <= '0;
    end else if (bus.rdy_in) begin
      if (bus.clear_all) begin
        busy_q      <= '0;
        rs_to_rob_q <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++)
          if (busy_q[i]) begin
            {qjb_q[i], vj_q[i]} <= snoop(qjb_q[i], qj_q[i], vj_q[i]);
            {qkb_q[i], vk_q[i]} <= snoop(qkb_q[i], qk_q[i], vk_q[i]);
          end
        if (bus.issue_valid && !full) begin
          busy_q[free_idx]               <= 1'b1;
          op_q[free_idx]                 <= bus.issue_op;
          dest_q[free_idx]               <= bus.issue_dest;
          pc_q[free_idx]                 <= bus.issue_pc;
          qj_q[free_idx]                 <= bus.issue_qj;
          qk_q[free_idx]                 <= bus.issue_qk;
          {qjb_q[free_idx], vj_q[free_idx]} <= snoop(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj);
          {qkb_q[free_idx], vk_q[free_idx]} <= snoop(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk);
        end
        if (sel_vld) begin
          busy_q[sel] <= 1'b0;
          rs_value_q  <= res;
          rs_dest_q   <= dest_q[sel];
        end
        rs_to_rob_q <= sel_vld;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed test-plan steps followed by random traffic, all compared against a cycle model.
module tb_alu_rs;
  localparam int W = 4;
  localparam int N = 8;
  localparam logic [5:0] ADD = 0, SUB = 1, AND_ = 2, OR_ = 3, XOR_ = 4, SLL = 5, SRL = 6, SRA = 7,
    SLT = 8, SLTU = 9, ADDI = 10, ANDI = 11, ORI = 12, XORI = 13, SLLI = 14, SRLI = 15, SRAI = 16,
    SLTI = 17, SLTIU = 18, LUI = 19, AUIPC = 20, JAL = 21, JALR = 22, BEQ = 23, BNE = 24, BLT = 25,
    BGE = 26, BLTU = 27, BGEU = 28;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   checks = 0, passes = 0, fails = 0;
  alu_rs_if bus ();
  alu_rs #(.RS_SIZE(N), .RS_IDX_BIT(3)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  logic         m_busy [N];
  logic         m_pj   [N];
  logic         m_pk   [N];
  logic [5:0]   m_op   [N];
  logic [W-1:0] m_dest [N];
  logic [W-1:0] m_tj   [N];
  logic [W-1:0] m_tk   [N];
  logic [31:0]  m_pc   [N];
  logic [31:0]  m_vj   [N];
  logic [31:0]  m_vk   [N];
  logic         out_v = 1'b0;
  logic [31:0]  out_val = '0;
  logic [W-1:0] out_dest = '0;
  logic [W-1:0] next_tag = '0;
  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    logic lt_s, lt_u;
    int unsigned sh;
    logic [31:0] fill;
    lt_u = a < b;
    lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    sh = b % 32;
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
    case (op)
      ADD, ADDI:   return a + b;
      SUB:         return a - b;
      AND_, ANDI:  return a & b;
      OR_, ORI:    return a | b;
      XOR_, XORI:  return a ^ b;
      SLL, SLLI:   return a << sh;
      SRL, SRLI:   return a >> sh;
      SRA, SRAI:   return (a >> sh) | fill;
      SLT, SLTI:   return {31'd0, lt_s};
      SLTU, SLTIU: return {31'd0, lt_u};
      LUI:         return b;
      AUIPC:       return pc + b;
      JAL, JALR:   return pc + 32'd4;
      BEQ:         return {31'd0, a == b};
      BNE:         return {31'd0, a != b};
      BLT:         return {31'd0, lt_s};
      BGE:         return {31'd0, !lt_s};
      BLTU:        return {31'd0, lt_u};
      BGEU:        return {31'd0, !lt_u};
      default:     return 32'd0;
    endcase
  endfunction
  function automatic logic model_full();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic logic [32:0] resolve(input logic p, input logic [W-1:0] t, input logic [31:0] v);
    if (p && bus.lb_to_rob && bus.lb_dest == t) return {1'b0, bus.lb_value};
    if (p && out_v && out_dest == t) return {1'b0, out_val};
    return {p, v};
  endfunction
  task automatic model_step();
    int sel, fi;
    logic [31:0] r;
`ifdef RS_OLDEST_FIRST_EN
    int best, age;
    best = 1 << W;
`endif
    sel = -1;
    fi = -1;
    r = '0;
    if (rst_in) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      out_v = 1'b0; out_val = '0; out_dest = '0;
      return;
    end
    if (!bus.rdy_in) return;
    if (bus.clear_all) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      out_v = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++)
      if (m_busy[i] && !m_pj[i] && !m_pk[i]) begin
`ifdef RS_OLDEST_FIRST_EN
        age = (int'(m_dest[i]) - int'(bus.rob_head) + (1 << W)) % (1 << W);
        if (age < best) begin best = age; sel = i; end
`else
        if (sel < 0) sel = i;
`endif
      end
    for (int i = 0; i < N; i++) if (fi < 0 && !m_busy[i]) fi = i;
    if (sel >= 0) r = alu_ref(m_op[sel], m_vj[sel], m_vk[sel], m_pc[sel]);
    for (int i = 0; i < N; i++)
      if (m_busy[i]) begin
        {m_pj[i], m_vj[i]} = resolve(m_pj[i], m_tj[i], m_vj[i]);
        {m_pk[i], m_vk[i]} = resolve(m_pk[i], m_tk[i], m_vk[i]);
      end
    if (bus.issue_valid && fi >= 0) begin
      m_busy[fi] = 1'b1; m_op[fi] = bus.issue_op; m_dest[fi] = bus.issue_dest; m_pc[fi] = bus.issue_pc;
      m_tj[fi] = bus.issue_qj; m_tk[fi] = bus.issue_qk;
      {m_pj[fi], m_vj[fi]} = resolve(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj);
      {m_pk[fi], m_vk[fi]} = resolve(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk);
    end
    if (sel >= 0) begin
      m_busy[sel] = 1'b0;
      out_val = r;
      out_dest = m_dest[sel];
    end
    out_v = (sel >= 0);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    chk("rs_to_rob", 32'(bus.rs_to_rob), 32'(out_v));
    chk("rs_dest", 32'(bus.rs_dest), 32'(out_dest));
    chk("rs_value", bus.rs_value, out_val);
    chk("rs_full", 32'(bus.rs_full), 32'(model_full()));
  endtask
  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.lb_to_rob = 1'b0;
    bus.clear_all = 1'b0;
  endtask
  task automatic iss(input logic [5:0] op, input logic [W-1:0] d, input logic [31:0] pc,
                     input logic [31:0] vj, input logic [31:0] vk,
                     input logic pj, input logic [W-1:0] tj, input logic pk, input logic [W-1:0] tk);
    bus.issue_valid = 1'b1; bus.issue_op = op; bus.issue_dest = d; bus.issue_pc = pc;
    bus.issue_vj = vj; bus.issue_vk = vk;
    bus.issue_qj_busy = pj; bus.issue_qj = tj; bus.issue_qk_busy = pk; bus.issue_qk = tk;
  endtask
  task automatic lb(input logic [W-1:0] d, input logic [31:0] v);
    bus.lb_to_rob = 1'b1; bus.lb_dest = d; bus.lb_value = v;
  endtask
  initial begin
    logic [W-1:0] d;
    logic [31:0] vj;
    int r;
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0; m_pj[i] = 1'b0; m_pk[i] = 1'b0; m_op[i] = '0; m_dest[i] = '0;
      m_tj[i] = '0; m_tk[i] = '0; m_pc[i] = '0; m_vj[i] = '0; m_vk[i] = '0;
    end
    bus.rdy_in = 1'b1; bus.rob_head = '0; bus.lb_dest = '0; bus.lb_value = '0;
    iss(ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    tick();
    tick();
    chk("reset_to_rob", 32'(bus.rs_to_rob), 32'd0);
    chk("reset_value", bus.rs_value, 32'd0);
    chk("reset_dest", 32'(bus.rs_dest), 32'd0);
    chk("reset_full", 32'(bus.rs_full), 32'd0);
    rst_in = 1'b0;
    iss(ADD, 2, 0, 5, 7, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    chk("add_valid", 32'(bus.rs_to_rob), 32'd1);
    chk("add_dest", 32'(bus.rs_dest), 32'd2);
    chk("add_value", bus.rs_value, 32'd12);
    tick();
    chk("add_pulse_end", 32'(bus.rs_to_rob), 32'd0);
    iss(SUB, 3, 0, 0, 1, 1, 6, 0, 0);
    tick();
    idle();
    tick();
    lb(6, 10);
    tick();
    chk("sub_no_early", 32'(bus.rs_to_rob), 32'd0);
    idle();
    tick();
    chk("sub_valid", 32'(bus.rs_to_rob), 32'd1);
    chk("sub_value", bus.rs_value, 32'd9);
    chk("sub_dest", 32'(bus.rs_dest), 32'd3);
    iss(ADDI, 1, 0, 3, 4, 0, 0, 0, 0);
    tick();
    iss(ADD, 4, 0, 0, 1, 1, 1, 0, 0);
    tick();
    chk("chain1_dest", 32'(bus.rs_dest), 32'd1);
    chk("chain1_value", bus.rs_value, 32'd7);
    idle();
    tick();
    chk("chain_gap", 32'(bus.rs_to_rob), 32'd0);
    tick();
    chk("chain2_dest", 32'(bus.rs_dest), 32'd4);
    chk("chain2_value", bus.rs_value, 32'd8);
    for (int i = 0; i < N; i++) begin
      iss(ADDI, W'(8 + i), 0, 0, 32'(i), 1, 7, 0, 0);
      tick();
    end
    idle();
    chk("fill_full", 32'(bus.rs_full), 32'd1);
    lb(7, 1);
    tick();
    idle();
    for (int i = 0; i < N; i++) begin
      tick();
      chk("drain_valid", 32'(bus.rs_to_rob), 32'd1);
      chk("drain_dest", 32'(bus.rs_dest), 32'(8 + i));
      chk("drain_value", bus.rs_value, 32'(1 + i));
      if (i == 0) chk("drain_full_drop", 32'(bus.rs_full), 32'd0);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      iss(ADD, W'(1 + i), 0, 0, 0, 1, 5, 0, 0);
      tick();
    end
    iss(ADD, 9, 0, 1, 1, 0, 0, 0, 0);
    bus.clear_all = 1'b1;
    tick();
    idle();
    chk("clear_full", 32'(bus.rs_full), 32'd0);
    chk("clear_to_rob", 32'(bus.rs_to_rob), 32'd0);
    lb(5, 32'h55);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clear_no_result", 32'(bus.rs_to_rob), 32'd0);
    end
    iss(BLT, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    tick();
    iss(BLTU, 2, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    tick();
    chk("blt_value", bus.rs_value, 32'd1);
    iss(SRA, 3, 0, 32'h8000_0000, 33, 0, 0, 0, 0);
    tick();
    chk("bltu_value", bus.rs_value, 32'd0);
    idle();
    tick();
    chk("sra_value", bus.rs_value, 32'hC000_0000);
    tick();
    bus.rob_head = 6;
    iss(ADDI, 1, 0, 0, 0, 1, 9, 0, 0);
    tick();
    iss(ADDI, 7, 0, 0, 0, 1, 9, 0, 0);
    tick();
    idle();
    lb(9, 5);
    tick();
    idle();
    tick();
`ifdef RS_OLDEST_FIRST_EN
    chk("age_first", 32'(bus.rs_dest), 32'd7);
`else
    chk("index_first", 32'(bus.rs_dest), 32'd1);
`endif
    tick();
    bus.rdy_in = 1'b0;
    iss(ADD, 5, 0, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_hold", 32'(bus.rs_to_rob), 32'd1);
    end
    bus.rdy_in = 1'b1;
    idle();
    tick();
    chk("pause_dropped", 32'(bus.rs_to_rob), 32'd0);
    iss(ADD, 5, 0, 1, 2, 0, 0, 0, 0);
    tick();
    idle();
    tick();
    chk("post_pause_value", bus.rs_value, 32'd3);
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst_in = ($urandom_range(0, 499) == 0);
      bus.rdy_in = ($urandom_range(0, 9) != 0);
      bus.clear_all = ($urandom_range(0, 80) == 0);
      bus.rob_head = W'($urandom);
      if ($urandom_range(0, 2) != 0 && (!model_full() || $urandom_range(0, 7) == 0)) begin
        r = $urandom_range(0, 29);
        vj = $urandom;
        iss(r == 29 ? 6'd63 : 6'(r), next_tag, $urandom, vj, $urandom_range(0, 3) == 0 ? vj : $urandom,
            $urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 2) == 0, W'($urandom));
        next_tag = next_tag + 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        d = W'($urandom);
        if (out_v && d == out_dest) d = d + 1'b1;
        lb(d, $urandom);
      end
      tick();
    end
    rst_in = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
